// File: rtl/wb_arbiter.sv
// Write-back port arbiter: shares the register file write port between the
// in-order pipeline and a 2-entry buffer of multi-cycle results.
module wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wreg_i,
  input  logic [4:0]  pipe_wd_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        mc_valid_i,
  input  logic [4:0]  mc_wd_i,
  input  logic [31:0] mc_wdata_i,
  output logic        mc_ready_o,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic [31:0] pend_mask_o
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  typedef enum logic [1:0] {GNT_IDLE, GNT_PIPE, GNT_BUF} gnt_e;

  logic [1:0]  live_q, live_d;
  logic [4:0]  ent_wd_q [2];
  logic [4:0]  ent_wd_d [2];
  logic [31:0] ent_data_q [2];
  logic [31:0] ent_data_d [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [3:0]  age_q, age_d;
  logic        wreg_q, wreg_d;
  logic [4:0]  wd_q, wd_d;
  logic [31:0] wdata_q, wdata_d;

  gnt_e gnt;
  logic pipe_valid;
  logic push;
  logic pop;

  assign stall_req_o = (count_q == 2'd2) || ((count_q != 2'd0) && (age_q >= MAX_WAIT_L));
  assign mc_ready_o  = (count_q != 2'd2);
  assign wreg_o      = wreg_q;
  assign wd_o        = wd_q;
  assign wdata_o     = wdata_q;

  always_comb begin
    pend_mask_o = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (live_q[i]) pend_mask_o[ent_wd_q[i]] = 1'b1;
    end
  end

  assign pipe_valid = pipe_wreg_i && (pipe_wd_i != 5'd0);

  always_comb begin
    gnt = GNT_IDLE;
    if (stall_req_o)           gnt = GNT_BUF;
    else if (pipe_valid)       gnt = GNT_PIPE;
    else if (count_q != 2'd0)  gnt = GNT_BUF;
  end

  // Handshakes to x0 complete (ready honoured) but never allocate an entry.
  assign push = mc_valid_i && mc_ready_o && (mc_wd_i != 5'd0);
  assign pop  = (gnt == GNT_BUF);

  always_comb begin
    live_d     = live_q;
    ent_wd_d   = ent_wd_q;
    ent_data_d = ent_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    wreg_d     = 1'b0;
    wd_d       = wd_q;
    wdata_d    = wdata_q;

    case (gnt)
      GNT_PIPE: begin
        wreg_d  = 1'b1;
        wd_d    = pipe_wd_i;
        wdata_d = pipe_wdata_i;
        for (int unsigned i = 0; i < 2; i++) begin
          if (ent_wd_q[i] == pipe_wd_i) live_d[i] = 1'b0;
        end
      end
      GNT_BUF: begin
        if (live_q[head_q]) begin
          wreg_d  = 1'b1;
          wd_d    = ent_wd_q[head_q];
          wdata_d = ent_data_q[head_q];
        end
        live_d[head_q] = 1'b0;
        head_d         = ~head_q;
      end
      default: ;
    endcase

    // Tail never aliases the popped head: a pop with push implies count was 1.
    if (push) begin
      ent_wd_d[tail_q]   = mc_wd_i;
      ent_data_d[tail_q] = mc_wdata_i;
      live_d[tail_q]     = !((gnt == GNT_PIPE) && (mc_wd_i == pipe_wd_i));
      tail_d             = ~tail_q;
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (pop || (count_d == 2'd0) || (count_q == 2'd0)) age_d = '0;
    else if (age_q != 4'hF)                            age_d = age_q + 4'd1;
    else                                               age_d = age_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q     <= '0;
      ent_wd_q   <= '{default: '0};
      ent_data_q <= '{default: '0};
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= '0;
      age_q      <= '0;
      wreg_q     <= 1'b0;
      wd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      live_q     <= live_d;
      ent_wd_q   <= ent_wd_d;
      ent_data_q <= ent_data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      age_q      <= age_d;
      wreg_q     <= wreg_d;
      wd_q       <= wd_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wreg_i = 1'b0;
  logic [4:0]  pipe_wd_i = '0;
  logic [31:0] pipe_wdata_i = '0;
  logic        mc_valid_i = 1'b0;
  logic [4:0]  mc_wd_i = '0;
  logic [31:0] mc_wdata_i = '0;
  logic        mc_ready_o;
  logic        wreg_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic [31:0] pend_mask_o;

  wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wreg_i(pipe_wreg_i), .pipe_wd_i(pipe_wd_i), .pipe_wdata_i(pipe_wdata_i),
    .mc_valid_i(mc_valid_i), .mc_wd_i(mc_wd_i), .mc_wdata_i(mc_wdata_i),
    .mc_ready_o(mc_ready_o), .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o),
    .stall_req_o(stall_req_o), .pend_mask_o(pend_mask_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        live;
    bit [4:0]  wd;
    bit [31:0] data;
  } ent_t;

  ent_t      q[$];
  int        age = 0;
  bit        m_wreg = 0;
  bit [4:0]  m_wd = '0;
  bit [31:0] m_wdata = '0;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic bit m_stall();
    return (q.size() == 2) || (q.size() > 0 && age >= MAX_WAIT);
  endfunction

  function automatic bit m_ready();
    return q.size() < 2;
  endfunction

  function automatic bit [31:0] m_mask();
    bit [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].wd] = 1'b1;
    return m;
  endfunction

  // One cycle of the architectural rules, applied to the inputs now driven.
  task automatic mstep();
    int  n;
    bit  stall, ready, pipe_ok, popped, piped;
    ent_t e;
    if (rst) begin
      q.delete();
      age = 0; m_wreg = 0; m_wd = '0; m_wdata = '0;
      return;
    end
    n = q.size();
    stall = m_stall();
    ready = m_ready();
    pipe_ok = pipe_wreg_i && (pipe_wd_i != 0);
    popped = 0; piped = 0; m_wreg = 0;
    if (stall || (!pipe_ok && n > 0)) begin
      e = q.pop_front();
      popped = 1;
      if (e.live) begin m_wreg = 1; m_wd = e.wd; m_wdata = e.data; end
    end else if (pipe_ok) begin
      piped = 1;
      m_wreg = 1; m_wd = pipe_wd_i; m_wdata = pipe_wdata_i;
      for (int i = 0; i < q.size(); i++) if (q[i].wd == pipe_wd_i) q[i].live = 0;
    end
    if (mc_valid_i && ready && mc_wd_i != 0) begin
      e.live = !(piped && mc_wd_i == pipe_wd_i);
      e.wd = mc_wd_i; e.data = mc_wdata_i;
      q.push_back(e);
    end
    if (popped || q.size() == 0 || n == 0) age = 0;
    else if (age < 15) age = age + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("wreg_o", {31'd0, wreg_o}, {31'd0, m_wreg});
    chk("wd_o", {27'd0, wd_o}, {27'd0, m_wd});
    chk("wdata_o", wdata_o, m_wdata);
    chk("stall_req_o", {31'd0, stall_req_o}, {31'd0, m_stall()});
    chk("mc_ready_o", {31'd0, mc_ready_o}, {31'd0, m_ready()});
    chk("pend_mask_o", pend_mask_o, m_mask());
  endtask

  task automatic cyc(input bit r, input bit pw, input bit [4:0] pwd, input bit [31:0] pdat,
                     input bit mv, input bit [4:0] mwd, input bit [31:0] mdat);
    rst = r;
    pipe_wreg_i = pw; pipe_wd_i = pwd; pipe_wdata_i = pdat;
    mc_valid_i = mv; mc_wd_i = mwd; mc_wdata_i = mdat;
    mstep();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit        pw, mv, r;
    bit [4:0]  pwd, mwd;
    bit [31:0] pdat, mdat;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_ready", {31'd0, mc_ready_o}, 32'd1);
    chk("rst_mask", pend_mask_o, 32'd0);

    // Pipeline only
    cyc(0, 1, 5'd5, 32'h11, 0, 0, 0);
    chk("pipe_x5_wd", {27'd0, wd_o}, 32'd5);
    chk("pipe_x5_data", wdata_o, 32'h11);
    cyc(0, 1, 5'd6, 32'h22, 0, 0, 0);
    chk("pipe_x6_wreg", {31'd0, wreg_o}, 32'd1);
    chk("pipe_x6_data", wdata_o, 32'h22);
    chk("pipe_stall", {31'd0, stall_req_o}, 32'd0);
    idle();
    chk("idle_wreg", {31'd0, wreg_o}, 32'd0);
    chk("idle_wd_hold", {27'd0, wd_o}, 32'd6);

    // Idle drain
    cyc(0, 0, 0, 0, 1, 5'd7, 32'hAB);
    chk("drain_mask", pend_mask_o, 32'h80);
    chk("drain_nowrite", {31'd0, wreg_o}, 32'd0);
    idle();
    chk("drain_wd", {27'd0, wd_o}, 32'd7);
    chk("drain_data", wdata_o, 32'hAB);
    chk("drain_mask_clr", pend_mask_o, 32'd0);

    // Full buffer under continuous pipeline writes
    cyc(0, 1, 5'd1, 32'hD1, 1, 5'd8, 32'h88);
    cyc(0, 1, 5'd2, 32'hD2, 1, 5'd10, 32'hA0);
    chk("full_stall", {31'd0, stall_req_o}, 32'd1);
    chk("full_ready", {31'd0, mc_ready_o}, 32'd0);
    cyc(0, 1, 5'd3, 32'hD3, 0, 0, 0);
    chk("full_pop1", {27'd0, wd_o}, 32'd8);
    chk("full_pop1_data", wdata_o, 32'h88);
    cyc(0, 1, 5'd3, 32'hD3, 0, 0, 0);
    chk("full_held_pipe", {27'd0, wd_o}, 32'd3);
    idle();
    chk("full_pop2", {27'd0, wd_o}, 32'd10);

    // Starvation
    cyc(0, 1, 5'd1, 32'hE1, 1, 5'd11, 32'hBB);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 1, 5'(12 + k), 32'(k), 0, 0, 0);
      chk("starve_pipe_wd", {27'd0, wd_o}, 32'(12 + k));
      chk("starve_stall", {31'd0, stall_req_o}, (k == 4) ? 32'd1 : 32'd0);
    end
    cyc(0, 1, 5'd20, 32'h20, 0, 0, 0);
    chk("starve_drain_wd", {27'd0, wd_o}, 32'd11);
    chk("starve_drain_data", wdata_o, 32'hBB);
    cyc(0, 1, 5'd20, 32'h20, 0, 0, 0);
    chk("starve_resume", {27'd0, wd_o}, 32'd20);

    // Squash
    cyc(0, 0, 0, 0, 1, 5'd9, 32'h1);
    chk("squash_mask_set", pend_mask_o, 32'h200);
    cyc(0, 1, 5'd9, 32'h2, 0, 0, 0);
    chk("squash_pipe_data", wdata_o, 32'h2);
    chk("squash_mask_clr", pend_mask_o, 32'd0);
    idle();
    chk("squash_nowrite", {31'd0, wreg_o}, 32'd0);
    chk("squash_data_hold", wdata_o, 32'h2);

    // x0 handling
    cyc(0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h5);
    chk("x0_pipe_nowrite", {31'd0, wreg_o}, 32'd0);
    chk("x0_mc_noalloc", pend_mask_o, 32'd0);
    idle();
    chk("x0_mc_nodrain", {31'd0, wreg_o}, 32'd0);

    // Reset with a full buffer
    cyc(0, 1, 5'd1, 32'hF1, 1, 5'd12, 32'hC);
    cyc(0, 1, 5'd2, 32'hF2, 1, 5'd13, 32'hD);
    chk("prerst_mask", pend_mask_o, 32'h3000);
    cyc(1, 1, 5'd3, 32'hF3, 0, 0, 0);
    chk("midrst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("midrst_mask", pend_mask_o, 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("midrst_no_write", {31'd0, wreg_o}, 32'd0);
    end

    // Random traffic; the pipeline and mc source hold their inputs when refused.
    pw = 0; pwd = '0; pdat = '0; mv = 0; mwd = '0; mdat = '0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 249) == 0);
      if (!m_stall()) begin
        pw = ($urandom_range(0, 3) != 0);
        pwd = 5'($urandom_range(0, 7));
        pdat = $urandom;
      end
      if (!(mv && !m_ready())) begin
        mv = ($urandom_range(0, 2) == 0);
        mwd = 5'($urandom_range(0, 7));
        mdat = $urandom;
      end
      cyc(r, pw, pwd, pdat, mv, mwd, mdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
